// File: rtl/uart_mem_dump.sv
// uart_mem_dump: RIB read master that streams a block of 32-bit words out of an 8N1 UART TX pin.
// Define UART_DUMP_HDR_EN to prefix the dump with three header frames (0xA5, count lo, count hi).
module uart_mem_dump #(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  output logic             req_o,
  output logic             we_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  input  logic [31:0]      rdata_i,
  input  logic             ready_i,
  output logic             tx_pin,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE, HDR, RD_REQ, TX_START, TX_DATA, TX_STOP, NEXT, DONE
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
`ifdef UART_DUMP_HDR_EN
  localparam state_t FIRST_STATE = HDR;
`else
  localparam state_t FIRST_STATE = RD_REQ;
`endif

  state_t           state, next_state;
  logic [31:0]      addr;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      shift;
  logic [1:0]       byte_idx;
  logic [2:0]       bit_idx;
  logic [15:0]      bit_cnt;
  logic             bit_done;
  logic             in_tx;
  logic             last_byte;
`ifdef UART_DUMP_HDR_EN
  logic             hdr_active;
  logic [15:0]      hdr_cnt;

  assign hdr_cnt = 16'(remaining);
`endif

  assign bit_done  = (bit_cnt == 16'd0);
  assign in_tx     = (state == TX_START) || (state == TX_DATA) || (state == TX_STOP);
  assign last_byte = (byte_idx == 2'd3);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_i) next_state = (word_cnt_i == '0) ? DONE : FIRST_STATE;
`ifdef UART_DUMP_HDR_EN
      HDR:      next_state = TX_START;
`endif
      RD_REQ:   if (ready_i) next_state = TX_START;
      TX_START: if (bit_done) next_state = TX_DATA;
      TX_DATA:  if (bit_done && (bit_idx == 3'd7)) next_state = TX_STOP;
      TX_STOP: begin
        if (bit_done) begin
          if (!last_byte) next_state = TX_START;
`ifdef UART_DUMP_HDR_EN
          else if (hdr_active) next_state = RD_REQ;
`endif
          else next_state = NEXT;
        end
      end
      NEXT:     next_state = (remaining == CNT_W'(1)) ? DONE : RD_REQ;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_pin = 1'b1;
    case (state)
      TX_START: tx_pin = 1'b0;
      TX_DATA:  tx_pin = shift[bit_idx];
      default:  tx_pin = 1'b1;
    endcase
  end

  assign req_o  = (state == RD_REQ);
  assign we_o   = 1'b0;
  assign data_o = 32'h0;
  assign addr_o = addr;
  assign busy_o = (state != IDLE) && (state != DONE);
  assign done_o = (state == DONE);

  // The bit counter reloads on every bit boundary and whenever the line is not framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= 32'h0;
      remaining  <= '0;
      shift      <= 32'h0;
      byte_idx   <= 2'd0;
      bit_idx    <= 3'd0;
      bit_cnt    <= DIV_M1;
`ifdef UART_DUMP_HDR_EN
      hdr_active <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (in_tx && !bit_done) bit_cnt <= bit_cnt - 16'd1;
      else bit_cnt <= DIV_M1;
      case (state)
        IDLE: begin
          if (start_i && (word_cnt_i != '0)) begin
            addr      <= base_addr_i & 32'hFFFF_FFFC;
            remaining <= word_cnt_i;
          end
        end
`ifdef UART_DUMP_HDR_EN
        HDR: begin
          shift      <= {8'h00, hdr_cnt[15:8], hdr_cnt[7:0], 8'hA5};
          byte_idx   <= 2'd1;
          hdr_active <= 1'b1;
        end
`endif
        RD_REQ: begin
          if (ready_i) begin
            shift    <= rdata_i;
            byte_idx <= 2'd0;
`ifdef UART_DUMP_HDR_EN
            hdr_active <= 1'b0;
`endif
          end
        end
        TX_START: bit_idx <= 3'd0;
        TX_DATA:  if (bit_done) bit_idx <= bit_idx + 3'd1;
        TX_STOP: begin
          if (bit_done) begin
            shift <= {8'h00, shift[31:8]};
            if (!last_byte) byte_idx <= byte_idx + 2'd1;
          end
        end
        NEXT: begin
          remaining <= remaining - CNT_W'(1);
          addr      <= addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb_uart_mem_dump: table-driven directed bench with a cycle-exact UART frame decoder and a RIB slave model.
// Header expectations follow UART_DUMP_HDR_EN when the bench is compiled with it.
module tb_uart_mem_dump;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
`ifdef UART_DUMP_HDR_EN
  localparam int HDR_FRAMES = 3;
`else
  localparam int HDR_FRAMES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'h0;
  logic [15:0] word_cnt_i = 16'h0;
  logic        req_o, we_o;
  logic [31:0] addr_o, data_o;
  logic [31:0] rdata_i = 32'h0;
  logic        ready_i = 1'b0;
  logic        tx_pin, busy_o, done_o;

  uart_mem_dump #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .rdata_i(rdata_i), .ready_i(ready_i), .tx_pin(tx_pin),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [31:0]      base;
    logic [15:0]      cnt;
    logic [3:0]       delay;
    logic [2:0][31:0] words;
    logic [2:0][31:0] exp_addr;
    logic             mid_start;
  } vec_t;

  vec_t vecs[5];

  logic [7:0]  byte_q[$];
  int          start_q[$];
  logic [31:0] addr_q[$];
  int          ack_q[$];
  int          req_q[$];
  int          done_cnt, bus_err, busy_err, frame_bad;

  logic [FRAME-1:0] samples;
  bit               rx_active = 1'b0;
  bit               rx_ok;
  int               rx_pos;
  logic [7:0]       rx_byte;

  int          slave_delay = 0;
  logic [31:0] slave_words[4];
  int          slave_idx = 0;
  int          wait_ctr = 0;
  logic        req_prev = 1'b0, busy_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;

  int checks = 0;
  int failures = 0;

  // Negedge observer: decodes tx_pin frames sample by sample, polices the bus and plays the RIB slave.
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      ready_i   = 1'b0;
      wait_ctr  = 0;
      req_prev  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (rx_active) begin
        samples[rx_pos] = tx_pin;
        rx_pos++;
      end else if (tx_pin == 1'b0) begin
        rx_active  = 1'b1;
        samples    = '0;
        rx_pos     = 1;
        start_q.push_back(cyc);
      end
      if (rx_active && rx_pos == FRAME) begin
        rx_ok = (samples[0] == 1'b0) && (samples[9*DIV] == 1'b1);
        for (int b = 0; b < 10; b++)
          for (int s = 0; s < DIV; s++)
            if (samples[b*DIV+s] !== samples[b*DIV]) rx_ok = 1'b0;
        for (int b = 0; b < 8; b++) rx_byte[b] = samples[(b+1)*DIV];
        byte_q.push_back(rx_byte);
        if (!rx_ok) frame_bad++;
        rx_active = 1'b0;
      end

      if (we_o !== 1'b0 || data_o !== 32'h0) bus_err++;
      if (req_o && !req_prev) begin
        addr_q.push_back(addr_o);
        req_q.push_back(cyc);
        wait_ctr = 0;
      end
      if (req_prev && !req_o && !ready_i) bus_err++;
      if (req_prev && req_o && ready_i) bus_err++;
      if (req_prev && req_o && addr_o !== addr_prev) bus_err++;
      if (busy_prev && !busy_o && !done_o) busy_err++;
      if (done_o) done_cnt++;

      ready_i = 1'b0;
      if (req_o) begin
        if (wait_ctr == slave_delay) begin
          ready_i = 1'b1;
          rdata_i = slave_words[slave_idx % 4];
          slave_idx++;
          ack_q.push_back(cyc);
        end else begin
          wait_ctr++;
        end
      end
      req_prev  = req_o;
      addr_prev = addr_o;
      busy_prev = busy_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearObservations();
    byte_q.delete(); start_q.delete(); addr_q.delete(); ack_q.delete(); req_q.delete();
    done_cnt = 0; bus_err = 0; busy_err = 0; frame_bad = 0;
  endtask

  // Runs one dump from the table and checks bytes, addresses, framing, gaps and completion timing.
  task automatic applyStimulus(input vec_t v, input string tag);
    int         k, done_cyc, exp_done, last_ack, exp_gap, d, exp_first_req;
    bit         seen_done, pulsed;
    logic       busy_at_done;
    logic [7:0] exp_b[$];
    clearObservations();
    slave_delay = int'(v.delay);
    for (int i = 0; i < 3; i++) slave_words[i] = v.words[i];
    slave_words[3] = 32'h0;
    slave_idx = 0;
    base_addr_i = v.base;
    word_cnt_i  = v.cnt;
    start_i = 1'b1;
    k = cyc;
    tick();
    start_i = 1'b0;
    base_addr_i = 32'h0BAD_0000;
    word_cnt_i  = 16'd9;
    checkOutput($sformatf("%s busy after start", tag), 32'(busy_o), 32'(v.cnt != 0));
    checkOutput($sformatf("%s req after start", tag), 32'(req_o), 32'((v.cnt != 0) && (HDR_FRAMES == 0)));

    seen_done = 1'b0; pulsed = 1'b0; done_cyc = 0; busy_at_done = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done_o) begin
        seen_done = 1'b1; done_cyc = cyc; busy_at_done = busy_o;
        break;
      end
      if (v.mid_start && !pulsed && start_q.size() == HDR_FRAMES + 3) begin
        start_i = 1'b1; word_cnt_i = 16'd5; base_addr_i = 32'h0; pulsed = 1'b1;
      end
      tick();
      start_i = 1'b0;
    end
    checkOutput($sformatf("%s done within budget", tag), 32'(seen_done), 32'd1);
    repeat (50) tick();

`ifdef UART_DUMP_HDR_EN
    if (v.cnt != 0) begin
      exp_b.push_back(8'hA5); exp_b.push_back(v.cnt[7:0]); exp_b.push_back(v.cnt[15:8]);
    end
`endif
    for (int w = 0; w < int'(v.cnt); w++)
      for (int b = 0; b < 4; b++) exp_b.push_back(v.words[w][8*b +: 8]);
    checkOutput($sformatf("%s frame count", tag), byte_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++)
      checkOutput($sformatf("%s byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_b[i]));
    checkOutput($sformatf("%s bad frames", tag), frame_bad, 0);

    checkOutput($sformatf("%s access count", tag), addr_q.size(), 32'(v.cnt));
    for (int i = 0; i < int'(v.cnt) && i < addr_q.size(); i++)
      checkOutput($sformatf("%s addr%0d", tag, i), addr_q[i], v.exp_addr[i]);
    checkOutput($sformatf("%s bus protocol errors", tag), bus_err, 0);
    checkOutput($sformatf("%s busy dropped early", tag), busy_err, 0);
    checkOutput($sformatf("%s done pulses", tag), done_cnt, 1);
    checkOutput($sformatf("%s busy at done", tag), 32'(busy_at_done), 32'd0);

    last_ack = (ack_q.size() > 0) ? ack_q[$] : -1;
    exp_done = (v.cnt == 0) ? k + 1 : last_ack + 4 * FRAME + 2;
    checkOutput($sformatf("%s done cycle", tag), done_cyc, exp_done);

    if (v.cnt != 0) begin
      exp_first_req = (HDR_FRAMES == 0) ? k + 1 : k + 2 + 3 * FRAME;
      if (req_q.size() > 0) checkOutput($sformatf("%s first req cycle", tag), req_q[0], exp_first_req);
      if (start_q.size() > 0)
        checkOutput($sformatf("%s first frame cycle", tag), start_q[0],
                    k + 2 + ((HDR_FRAMES == 0) ? int'(v.delay) : 0));
      for (int i = 1; i < start_q.size(); i++) begin
        d = i - HDR_FRAMES;
        if (d < 0 || (d > 0 && d % 4 != 0)) exp_gap = FRAME;
        else if (d == 0) exp_gap = FRAME + 1 + int'(v.delay);
        else exp_gap = FRAME + 2 + int'(v.delay);
        checkOutput($sformatf("%s frame gap%0d", tag, i), start_q[i] - start_q[i-1], exp_gap);
      end
    end
  endtask

  initial begin
    int k, n_frames;
    bit seen;

    vecs[0] = '0;
    vecs[0].base = 32'h1000_0000; vecs[0].cnt = 16'd1; vecs[0].delay = 4'd1;
    vecs[0].words[0] = 32'h4433_2211; vecs[0].exp_addr[0] = 32'h1000_0000;

    vecs[1] = '0;
    vecs[1].base = 32'hFFFF_FFF8; vecs[1].cnt = 16'd3; vecs[1].delay = 4'd5;
    vecs[1].words[0] = 32'hDEAD_BEEF; vecs[1].words[1] = 32'h0123_4567; vecs[1].words[2] = 32'h89AB_CDEF;
    vecs[1].exp_addr[0] = 32'hFFFF_FFF8; vecs[1].exp_addr[1] = 32'hFFFF_FFFC; vecs[1].exp_addr[2] = 32'h0000_0000;

    vecs[2] = '0;
    vecs[2].base = 32'h0000_0013; vecs[2].cnt = 16'd2; vecs[2].delay = 4'd0;
    vecs[2].words[0] = 32'hA5A5_5A5A; vecs[2].words[1] = 32'h00FF_7E81;
    vecs[2].exp_addr[0] = 32'h0000_0010; vecs[2].exp_addr[1] = 32'h0000_0014;

    vecs[3] = '0;
    vecs[3].base = 32'h2000_0000; vecs[3].cnt = 16'd2; vecs[3].delay = 4'd2; vecs[3].mid_start = 1'b1;
    vecs[3].words[0] = 32'hCAFE_F00D; vecs[3].words[1] = 32'h5A5A_0001;
    vecs[3].exp_addr[0] = 32'h2000_0000; vecs[3].exp_addr[1] = 32'h2000_0004;

    vecs[4] = '0;
    vecs[4].base = 32'h3000_0000; vecs[4].cnt = 16'd0; vecs[4].delay = 4'd0;

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset req_o", 32'(req_o), 32'd0);
    checkOutput("reset we_o", 32'(we_o), 32'd0);
    checkOutput("reset addr_o", addr_o, 32'h0);
    checkOutput("reset data_o", data_o, 32'h0);
    checkOutput("reset tx_pin", 32'(tx_pin), 32'd1);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset done_o", 32'(done_o), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort in the middle of a data bit, then prove a fresh dump still works.
    clearObservations();
    slave_delay = 0; slave_idx = 0;
    slave_words[0] = 32'h8765_4321; slave_words[1] = 32'h0F0F_F0F0;
    base_addr_i = 32'h0000_0300; word_cnt_i = 16'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (start_q.size() >= 2) begin seen = 1'b1; break; end
      tick();
    end
    checkOutput("abort second frame started", 32'(seen), 32'd1);
    repeat (DIV + 2) tick();
    rst = 1'b1;
    n_frames = start_q.size();
    tick();
    checkOutput("abort tx_pin", 32'(tx_pin), 32'd1);
    checkOutput("abort req_o", 32'(req_o), 32'd0);
    checkOutput("abort busy_o", 32'(busy_o), 32'd0);
    checkOutput("abort done_o", 32'(done_o), 32'd0);
    rst = 1'b0;
    repeat (3 * FRAME) tick();
    checkOutput("abort no done", done_cnt, 0);
    checkOutput("abort no new frames", start_q.size(), n_frames);
    checkOutput("abort line idle", 32'(tx_pin), 32'd1);
    applyStimulus(vecs[0], "after abort");

`ifdef UART_DUMP_HDR_EN
    // Large count: only the header and the first request are examined before aborting.
    clearObservations();
    slave_delay = 0; slave_idx = 0;
    base_addr_i = 32'h0000_0040; word_cnt_i = 16'h0102;
    start_i = 1'b1;
    k = cyc;
    tick();
    start_i = 1'b0;
    checkOutput("hdr busy after start", 32'(busy_o), 32'd1);
    checkOutput("hdr no req during header", 32'(req_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (req_q.size() >= 1) begin seen = 1'b1; break; end
      tick();
    end
    checkOutput("hdr req seen", 32'(seen), 32'd1);
    if (req_q.size() > 0) checkOutput("hdr first req cycle", req_q[0], k + 2 + 3 * FRAME);
    checkOutput("hdr frame count", byte_q.size(), 3);
    if (byte_q.size() >= 3) begin
      checkOutput("hdr byte0", 32'(byte_q[0]), 32'h0000_00A5);
      checkOutput("hdr byte1", 32'(byte_q[1]), 32'h0000_0002);
      checkOutput("hdr byte2", 32'(byte_q[2]), 32'h0000_0001);
    end
    checkOutput("hdr first addr", (addr_q.size() > 0) ? addr_q[0] : 32'hFFFF_FFFF, 32'h0000_0040);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
